// File: rtl/booth_operand_loader.sv
// Operand feeder for the radix-4 Booth multiplier.
// Buffers A/X pairs and streams them over the half-width bus.
module booth_operand_loader #(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inValid,
    output logic           inReady,
    input  logic [N-1:0]   inA,
    input  logic [N-1:0]   inX,
    output logic [N/2-1:0] inBus,
    output logic           lmA,
    output logic           ldA,
    output logic           lmX,
    output logic           ldX,
    output logic           mulStart,
    input  logic           mulDone,
    output logic           busy,
    output logic [7:0]     opCount
);

    localparam int HALF = N / 2;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALO,
        S_AHI,
        S_XLO,
        S_XHI,
        S_START,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [N-1:0]  r_memA [DEPTH];
    logic [N-1:0]  r_memX [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [7:0]    r_opCount;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [N-1:0]  w_hA;
    logic [N-1:0]  w_hX;

    assign w_full  = (r_cnt == C_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_push  = inValid & ~w_full;
    assign w_pop   = (r_state == S_START);
    assign w_hA    = r_memA[r_rp];
    assign w_hX    = r_memX[r_rp];
    assign inReady = ~w_full;
    assign opCount = r_opCount;

    // FIFO storage; entries need no reset, the count guards them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memA[r_wp] <= inA;
            r_memX[r_wp] <= inX;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + C_ONE;
                2'b01:   r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // State register and issued-operation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_opCount <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_opCount <= r_opCount + 8'd1;
        end
    end

    // Next-state and Moore outputs decoded from state and FIFO head
    always_comb begin
        w_next   = r_state;
        inBus    = '0;
        ldA      = 1'b0;
        lmA      = 1'b0;
        ldX      = 1'b0;
        lmX      = 1'b0;
        mulStart = 1'b0;
        busy     = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) w_next = S_ALO;
            end
            S_ALO: begin
                inBus  = w_hA[HALF-1:0];
                ldA    = 1'b1;
                w_next = S_AHI;
            end
            S_AHI: begin
                inBus  = w_hA[N-1:HALF];
                ldA    = 1'b1;
                lmA    = 1'b1;
                w_next = S_XLO;
            end
            S_XLO: begin
                inBus  = w_hX[HALF-1:0];
                ldX    = 1'b1;
                w_next = S_XHI;
            end
            S_XHI: begin
                inBus  = w_hX[N-1:HALF];
                ldX    = 1'b1;
                lmX    = 1'b1;
                w_next = S_START;
            end
            S_START: begin
                mulStart = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (mulDone) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_operand_loader.sv
// Directed bench for booth_operand_loader.
// Accepted pairs are queued and checked against the bytes streamed out.
module tb_booth_operand_loader;

    localparam int N     = 16;
    localparam int DEPTH = 2;
    localparam int H     = N / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inValid = 1'b0;
    logic         mulDone = 1'b0;
    logic [N-1:0] inA = '0;
    logic [N-1:0] inX = '0;
    logic         inReady;
    logic [H-1:0] inBus;
    logic         lmA, ldA, lmX, ldX;
    logic         mulStart;
    logic         busy;
    logic [7:0]   opCount;

    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    int             mcnt = 0;
    int             start_cyc = 0;
    logic [7:0]     mop = 8'd0;
    logic [2*N-1:0] sb [$];
    logic [N-1:0]   capA = 'x;
    logic [N-1:0]   capX = 'x;
    logic           last_acc = 1'b0;

    always #5 clk = ~clk;

    booth_operand_loader #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inA(inA), .inX(inX), .inBus(inBus),
        .lmA(lmA), .ldA(ldA), .lmX(lmX), .ldX(ldX),
        .mulStart(mulStart), .mulDone(mulDone),
        .busy(busy), .opCount(opCount)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic r, acc, pop;
        logic [2*N-1:0] e;
        r   = rst;
        acc = ((inValid && inReady) === 1'b1) && !r;
        pop = (mulStart === 1'b1);
        if (acc) sb.push_back({inA, inX});
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc;
        if (r) begin
            sb.delete();
            mcnt = 0;
            mop  = 8'd0;
            capA = 'x;
            capX = 'x;
        end else begin
            if (acc) mcnt++;
            if (pop) begin
                mcnt--;
                mop++;
            end
        end
        check("inReady", 64'(inReady), 64'(mcnt != DEPTH));
        check("opCount", 64'(opCount), 64'(mop));
        check("one_ld", 64'(ldA && ldX), 64'(0));
        check("lmA_needs_ldA", 64'(lmA && !ldA), 64'(0));
        check("lmX_needs_ldX", 64'(lmX && !ldX), 64'(0));
        if (!ldA && !ldX) check("bus_quiet", 64'(inBus), 64'(0));
        if (ldA && !lmA) capA[H-1:0] = inBus;
        if (ldA && lmA)  capA[N-1:H] = inBus;
        if (ldX && !lmX) capX[H-1:0] = inBus;
        if (ldX && lmX)  capX[N-1:H] = inBus;
        if (mulStart === 1'b1) begin
            check("start_has_pair", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pair_A", 64'(capA), 64'(e[2*N-1:N]));
                check("pair_X", 64'(capX), 64'(e[N-1:0]));
            end
            capA = 'x;
            capX = 'x;
            start_cyc = cyc;
        end
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] x);
        int n;
        n = 0;
        inValid = 1'b1;
        inA = a;
        inX = x;
        do begin
            step();
            n++;
        end while (!last_acc && n < 40);
        inValid = 1'b0;
        check("push_accept", 64'(last_acc), 64'(1));
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (mulStart !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("start_timeout", 64'(mulStart), 64'(1));
    endtask

    task automatic release_done();
        step();
        mulDone = 1'b1;
        step();
        mulDone = 1'b0;
    endtask

    initial begin
        int t;
        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_inReady", 64'(inReady), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_strobes", 64'({ldA, lmA, ldX, lmX, mulStart}), 64'(0));
        check("rst_bus", 64'(inBus), 64'(0));
        check("rst_opCount", 64'(opCount), 64'(0));

        // single operation, exact sequencing
        push(16'h1234, 16'hABCD);
        check("t1_idle", 64'(busy), 64'(0));
        step();
        check("t1_alo", 64'({inBus, ldA, lmA, ldX}), 64'({8'h34, 3'b100}));
        step();
        check("t1_ahi", 64'({inBus, ldA, lmA, ldX}), 64'({8'h12, 3'b110}));
        step();
        check("t1_xlo", 64'({inBus, ldX, lmX, ldA}), 64'({8'hCD, 3'b100}));
        step();
        check("t1_xhi", 64'({inBus, ldX, lmX, ldA}), 64'({8'hAB, 3'b110}));
        step();
        check("t1_start", 64'(mulStart), 64'(1));
        step();
        check("t1_wait", 64'({busy, mulStart}), 64'(2'b10));
        check("t1_opCount", 64'(opCount), 64'(1));
        step();
        step();
        mulDone = 1'b1;
        step();
        mulDone = 1'b0;
        check("t1_idle_after", 64'(busy), 64'(0));

        // back-to-back pushes against a full FIFO
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        check("t2_full", 64'(inReady), 64'(0));
        push(16'h5555, 16'h6666);
        step();
        step();
        step();
        check("t2_stall", 64'({busy, ldA, ldX, mulStart}), 64'(4'b1000));

        // drain in order with minimum spacing
        mulDone = 1'b1;
        step();
        mulDone = 1'b0;
        wait_start(20);
        t = start_cyc;
        release_done();
        wait_start(20);
        check("t3_spacing", 64'(start_cyc - t), 64'(7));
        release_done();
        check("t3_drained", 64'({busy, inReady}), 64'(2'b01));

        // mulDone held high outside WAIT is ignored
        push(16'hBEEF, 16'h0F0F);
        mulDone = 1'b1;
        step();
        check("t4_alo", 64'({ldA, lmA}), 64'(2'b10));
        step();
        step();
        step();
        step();
        check("t4_start", 64'(mulStart), 64'(1));
        step();
        check("t4_wait", 64'(busy), 64'(1));
        step();
        check("t4_exit", 64'(busy), 64'(0));
        mulDone = 1'b0;

        // reset in AHI drops buffered pairs
        push(16'hA5A5, 16'h5A5A);
        push(16'hC3C3, 16'h3C3C);
        step();
        check("t5_ahi", 64'({inBus, ldA, lmA}), 64'({8'hA5, 2'b11}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst", 64'({busy, inReady, ldA, lmA, ldX, lmX, mulStart}),
              64'(7'b0100000));
        check("t5_opCount", 64'(opCount), 64'(0));
        for (int i = 0; i < 12; i++) begin
            step();
            check("t5_quiet", 64'({busy, mulStart}), 64'(0));
        end

        // opCount wrap after 256 operations
        for (int i = 0; i < 256; i++) begin
            push(N'($urandom), N'($urandom));
            wait_start(20);
            release_done();
        end
        check("t6_wrap", 64'(opCount), 64'(0));
        check("t6_state", 64'({busy, inReady}), 64'(2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
